// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode, the ID/EX operand stage and the ALU.
// master: the side that presents decoded instructions and forwarding results.
// slave:  the operand stage itself.
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  // decode side
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic                      id_alu_src;
  logic [OPCODE_LENGTH-1:0]  id_operation;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      flush;
  // forwarding sources
  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr;
  logic                      exmem_reg_write;
  logic [DATA_WIDTH-1:0]     exmem_result;
  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr;
  logic                      memwb_reg_write;
  logic [DATA_WIDTH-1:0]     memwb_result;
  // stage outputs
  logic                      stall_req;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     SrcA;
  logic [DATA_WIDTH-1:0]     SrcB;
  logic [OPCODE_LENGTH-1:0]  Operation;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_reg_write;
  logic                      ex_mem_read;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_operation, id_rd_addr, id_reg_write, id_mem_read, flush,
           exmem_rd_addr, exmem_reg_write, exmem_result,
           memwb_rd_addr, memwb_reg_write, memwb_result,
    input  stall_req, ex_valid, SrcA, SrcB, Operation, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src, id_operation, id_rd_addr, id_reg_write, id_mem_read, flush,
           exmem_rd_addr, exmem_reg_write, exmem_result,
           memwb_rd_addr, memwb_reg_write, memwb_result,
    output stall_req, ex_valid, SrcA, SrcB, Operation, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: registers the decoded instruction, resolves both
// source operands through EX/MEM then MEM/WB forwarding, selects imm/rs2
// for SrcB and raises a one-cycle stall with a bubble on load-use hazards.

// Per-operand forwarding mux. EX/MEM is younger, so it wins; x0 never forwards.
module id_ex_fwd_sel #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     src_data,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd_data
);
  logic hit_exmem, hit_memwb;

  assign hit_exmem = exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == src_addr);
  assign hit_memwb = memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == src_addr);

  // priority select: EX/MEM, then MEM/WB, then register-file value
  always_comb begin
    fwd_data = src_data;
    if (hit_exmem)      fwd_data = exmem_result;
    else if (hit_memwb) fwd_data = memwb_result;
  end
endmodule

module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic              clk,
  input logic              reset,
  id_ex_operand_stage_if.slave bus
);
  localparam int NUM_SRC = 2;  // rs1, rs2

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      alu_src;
    logic [OPCODE_LENGTH-1:0]  operation;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_read;
  } stage_t;

  stage_t st, st_nxt;
  logic   stall;
  logic   load_hit;

  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0] src_addr;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     src_data;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     fwd_data;

  // Load-use: the load in EX has no data until MEM/WB, so hold decode one
  // cycle. rs2 is compared even for immediate forms (conservative). A flush
  // kills the dependent instruction, so no stall is needed then.
  assign load_hit = (st.rd_addr != '0) &&
                    ((st.rd_addr == bus.id_rs1_addr) || (st.rd_addr == bus.id_rs2_addr));
  assign stall    = bus.id_valid && st.valid && st.mem_read && load_hit && !bus.flush;

  // next-state: flush and stall load a bubble, otherwise capture decode
  always_comb begin
    st_nxt = '0;
    if (!bus.flush && !stall && bus.id_valid) begin
      st_nxt.valid     = 1'b1;
      st_nxt.rs1_addr  = bus.id_rs1_addr;
      st_nxt.rs2_addr  = bus.id_rs2_addr;
      st_nxt.rs1_data  = bus.id_rs1_data;
      st_nxt.rs2_data  = bus.id_rs2_data;
      st_nxt.imm       = bus.id_imm;
      st_nxt.alu_src   = bus.id_alu_src;
      st_nxt.operation = bus.id_operation;
      st_nxt.rd_addr   = bus.id_rd_addr;
      st_nxt.reg_write = bus.id_reg_write;
      st_nxt.mem_read  = bus.id_mem_read;
    end
  end

  // stage register, synchronous reset clears every field
  always_ff @(posedge clk) begin
    if (reset) st <= '0;
    else       st <= st_nxt;
  end

  assign src_addr[0] = st.rs1_addr;
  assign src_addr[1] = st.rs2_addr;
  assign src_data[0] = st.rs1_data;
  assign src_data[1] = st.rs2_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    id_ex_fwd_sel #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd (
      .src_addr       (src_addr[g]),
      .src_data       (src_data[g]),
      .exmem_rd_addr  (bus.exmem_rd_addr),
      .exmem_reg_write(bus.exmem_reg_write),
      .exmem_result   (bus.exmem_result),
      .memwb_rd_addr  (bus.memwb_rd_addr),
      .memwb_reg_write(bus.memwb_reg_write),
      .memwb_result   (bus.memwb_result),
      .fwd_data       (fwd_data[g])
    );
  end

  assign bus.stall_req     = stall;
  assign bus.ex_valid      = st.valid;
  assign bus.SrcA          = fwd_data[0];
  assign bus.SrcB          = st.alu_src ? st.imm : fwd_data[1];
  assign bus.ex_store_data = fwd_data[1];
  assign bus.Operation     = st.operation;
  assign bus.ex_rd_addr    = st.rd_addr;
  assign bus.ex_reg_write  = st.reg_write;
  assign bus.ex_mem_read   = st.mem_read;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: the driver pushes hand-computed
// expectations tagged with the cycle they apply to; a negedge monitor pops
// and compares them.
module tb_id_ex_operand_stage;
  localparam int DW = 32, OW = 4, AW = 5;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_ex_operand_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) bus ();

  id_ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic        valid;
    logic [31:0] a, b, st;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, stall;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1a, input logic [31:0] r1d,
                        input logic [4:0] r2a, input logic [31:0] r2d, input logic [31:0] imm,
                        input logic asrc, input logic [3:0] op, input logic [4:0] rd,
                        input logic rw, input logic mr);
    bus.id_valid = v;   bus.id_rs1_addr = r1a; bus.id_rs1_data = r1d;
    bus.id_rs2_addr = r2a; bus.id_rs2_data = r2d; bus.id_imm = imm;
    bus.id_alu_src = asrc; bus.id_operation = op; bus.id_rd_addr = rd;
    bus.id_reg_write = rw; bus.id_mem_read = mr;
  endtask

  task automatic set_fwd(input logic [4:0] xrd, input logic xrw, input logic [31:0] xres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    bus.exmem_rd_addr = xrd; bus.exmem_reg_write = xrw; bus.exmem_result = xres;
    bus.memwb_rd_addr = wrd; bus.memwb_reg_write = wrw; bus.memwb_result = wres;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] st, input logic [3:0] op,
                            input logic [4:0] rd, input logic rw, input logic mr,
                            input logic stall);
    exp_t e;
    e.cyc = cyc; e.name = name; e.valid = v; e.a = a; e.b = b; e.st = st; e.op = op;
    e.rd = rd; e.rw = rw; e.mr = mr; e.stall = stall;
    sb.push_back(e);
  endtask

  // monitor: compare whatever expectation is due in the current cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t m;
      m = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: expectation missed its cycle (due %0d, now %0d)", m.name, m.cyc, cyc);
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      logic [113:0] got, want;
      e = sb.pop_front();
      got  = {bus.ex_valid, bus.SrcA, bus.SrcB, bus.ex_store_data, bus.Operation,
              bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read, bus.stall_req};
      want = {e.valid, e.a, e.b, e.st, e.op, e.rd, e.rw, e.mr, e.stall};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got v=%b A=%h B=%h st=%h op=%h rd=%0d rw=%b mr=%b stall=%b | want v=%b A=%h B=%h st=%h op=%h rd=%0d rw=%b mr=%b stall=%b",
                 e.name, bus.ex_valid, bus.SrcA, bus.SrcB, bus.ex_store_data, bus.Operation,
                 bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read, bus.stall_req,
                 e.valid, e.a, e.b, e.st, e.op, e.rd, e.rw, e.mr, e.stall);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // reset state; present plain instruction
    reset = 1'b0;
    set_id(1, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 0, 4'b0010, 5'd5, 1, 0);
    expect_out("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // plain capture; present forwarding-test instruction (rs1=x3)
    tick();
    expect_out("plain_capture", 1, 32'd5, 32'd7, 32'd7, 4'b0010, 5'd5, 1, 0, 0);
    set_id(1, 5'd3, 32'h33, 5'd6, 32'h66, 32'd0, 0, 4'b0011, 5'd7, 1, 0);

    // both stages write x3: EX/MEM wins
    tick();
    set_fwd(5'd3, 1, 32'h11, 5'd3, 1, 32'h22);
    expect_out("fwd_exmem_wins", 1, 32'h11, 32'h66, 32'h66, 4'b0011, 5'd7, 1, 0, 0);

    // EX/MEM not writing: MEM/WB supplies
    tick();
    set_fwd(5'd3, 0, 32'h11, 5'd3, 1, 32'h22);
    expect_out("fwd_memwb", 1, 32'h22, 32'h66, 32'h66, 4'b0011, 5'd7, 1, 0, 0);

    // rd = x0 on both: registered data; present immediate-form instruction
    tick();
    set_fwd(5'd0, 1, 32'h11, 5'd0, 1, 32'h22);
    expect_out("fwd_x0_none", 1, 32'h33, 32'h66, 32'h66, 4'b0011, 5'd7, 1, 0, 0);
    set_id(1, 5'd8, 32'd1, 5'd9, 32'd2, 32'hFFFF_FFF0, 1, 4'b0110, 5'd10, 1, 0);

    // immediate select with rs2 forwarded; present load x4
    tick();
    set_fwd(5'd9, 1, 32'h9, 5'd0, 0, 32'h0);
    expect_out("imm_select", 1, 32'd1, 32'hFFFF_FFF0, 32'h9, 4'b0110, 5'd10, 1, 0, 0);
    set_id(1, 5'd1, 32'h100, 5'd0, 32'd0, 32'd4, 1, 4'b0010, 5'd4, 1, 1);

    // load in stage, dependent instruction on rs2 = x4 -> stall
    tick();
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd2, 32'h20, 5'd4, 32'hDEAD, 32'd0, 0, 4'b0001, 5'd11, 1, 0);
    expect_out("load_use_stall", 1, 32'h100, 32'd4, 32'd0, 4'b0010, 5'd4, 1, 1, 1);

    // bubble: forwarding cannot reach its zero addresses; stall drops
    tick();
    set_fwd(5'd4, 1, 32'h77, 5'd0, 0, 32'h0);
    expect_out("load_use_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // re-presented instruction captured, loaded value from MEM/WB
    tick();
    set_fwd(5'd0, 0, 32'h0, 5'd4, 1, 32'h55);
    expect_out("load_use_fwd", 1, 32'h20, 32'h55, 32'h55, 4'b0001, 5'd11, 1, 0, 0);
    set_id(1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd8, 1, 4'b0010, 5'd4, 1, 1);

    // load in stage, hazard present but flushed -> no stall
    tick();
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd4, 32'h1, 5'd3, 32'h2, 32'd0, 0, 4'b0001, 5'd13, 1, 0);
    bus.flush = 1'b1;
    expect_out("flush_no_stall", 1, 32'd0, 32'd8, 32'd0, 4'b0010, 5'd4, 1, 1, 0);

    // bubble from flush; present a valid instruction
    tick();
    bus.flush = 1'b0;
    set_id(1, 5'd1, 32'hA, 5'd2, 32'hB, 32'd0, 0, 4'b0100, 5'd12, 1, 0);
    expect_out("flush_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // valid in stage, then reset for one cycle
    tick();
    expect_out("pre_reset", 1, 32'hA, 32'hB, 32'hB, 4'b0100, 5'd12, 1, 0, 0);
    reset = 1'b1;

    tick();
    reset = 1'b0;
    set_fwd(5'd1, 1, 32'hBAD, 5'd2, 1, 32'hBAD);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_mid_op", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd12, 1, 4'b0010, 5'd4, 1, 1);

    // load in stage, hazard on rs1, reset asserted same cycle
    tick();
    set_id(1, 5'd4, 32'h3, 5'd0, 32'h0, 32'd0, 0, 4'b0001, 5'd14, 1, 0);
    reset = 1'b1;
    expect_out("stall_before_reset", 1, 32'd0, 32'd12, 32'd0, 4'b0010, 5'd4, 1, 1, 1);

    // reset wins; present instruction with id_valid = 0
    tick();
    reset = 1'b0;
    bus.id_valid = 1'b0;
    expect_out("reset_mid_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // id_valid = 0 captures a bubble
    tick();
    expect_out("invalid_capture", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // drain with a bound
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
